// File: rtl/alu_sweep_capture.sv
// Sweeps an external ALU through every opcode with latched operands and records
// each result in a small buffer that is read back through a registered port.
module alu_sweep_capture #(
  parameter int DW     = 4,
  parameter int SW     = 4,
  parameter int YW     = 6,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [YW-1:0] alu_y,
  output logic          busy,
  output logic          done,
  input  logic          rd_en,
  input  logic [SW-1:0] rd_addr,
  output logic [YW-1:0] rd_data,
  output logic          rd_valid
);

  localparam int DEPTH = 2 ** SW;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE);
  localparam logic [SW-1:0] SEL_LAST = SW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [YW-1:0] mem [DEPTH];
  logic          capture;

  // y is sampled on the last cycle an opcode is held
  assign capture = (state_reg == RUN) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            alu_a     <= op_a;
            alu_b     <= op_b;
            alu_sel   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!capture) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            cnt_reg <= '0;
            if (alu_sel == SEL_LAST) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              alu_sel <= alu_sel + 1'b1;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (capture) begin
      mem[alu_sel] <= alu_y;
    end
  end

  // Same-cycle read of an entry being captured sees the old contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_alu_sweep_capture.sv
// Directed bench for alu_sweep_capture with a y = a + b + sel ALU model,
// covering SETTLE=1 and SETTLE=0 builds side by side.
module tb_alu_sweep_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, rd_en, start_z, rd_en_z;
  logic [3:0] op_a, op_b, rd_addr, rd_addr_z;
  logic [3:0] alu_a, alu_b, alu_sel, alu_a_z, alu_b_z, alu_sel_z;
  logic [5:0] alu_y, alu_y_z, rd_data, rd_data_z;
  logic       busy, done, rd_valid, busy_z, done_z, rd_valid_z;

  assign alu_y   = 6'(alu_a) + 6'(alu_b) + 6'(alu_sel);
  assign alu_y_z = 6'(alu_a_z) + 6'(alu_b_z) + 6'(alu_sel_z);

  alu_sweep_capture #(.DW(4), .SW(4), .YW(6), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  alu_sweep_capture #(.DW(4), .SW(4), .YW(6), .SETTLE(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .op_a(op_a), .op_b(op_b),
    .alu_a(alu_a_z), .alu_b(alu_b_z), .alu_sel(alu_sel_z), .alu_y(alu_y_z),
    .busy(busy_z), .done(done_z), .rd_en(rd_en_z), .rd_addr(rd_addr_z),
    .rd_data(rd_data_z), .rd_valid(rd_valid_z)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input bit z, input int addr, output logic [31:0] data,
                         output logic [31:0] valid);
    if (z) begin
      rd_en_z = 1'b1; rd_addr_z = 4'(addr);
    end else begin
      rd_en = 1'b1; rd_addr = 4'(addr);
    end
    tick();
    data  = z ? 32'(rd_data_z) : 32'(rd_data);
    valid = z ? 32'(rd_valid_z) : 32'(rd_valid);
    rd_en = 1'b0;
    rd_en_z = 1'b0;
  endtask

  // Pulse start, then watch 50 cycles; cycle 1 is the first cycle after the start edge.
  task automatic sweep(input bit z, input int poke_at, output int busy_n,
                       output int done_at, output int done_n);
    if (z) start_z = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start_z = 1'b0;
    op_a = ~op_a;
    op_b = ~op_b;
    busy_n = 0; done_at = -1; done_n = 0;
    for (int c = 1; c <= 50; c++) begin
      if ((z ? busy_z : busy) === 1'b1) busy_n++;
      if ((z ? done_z : done) === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (!z) start = (c == poke_at);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic wait_sel(input int v);
    int n;
    n = 0;
    while (alu_sel !== 4'(v) && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("wait_sel_%0d_in_time", v), 32'(n < 100), 1);
  endtask

  initial begin
    logic [31:0] d, v;
    int bn, da, dn, cnt;

    rst_n = 1'b0; start = 1'b0; start_z = 1'b0; rd_en = 1'b0; rd_en_z = 1'b0;
    rd_addr = '0; rd_addr_z = '0; op_a = '0; op_b = '0;

    // Reset
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy_z", busy_z, 0);
    rst_n = 1'b1;
    tick();
    do_read(0, 9, d, v);
    check("rst_entry9", d, 0);
    check("rst_entry9_valid", v, 1);
    tick();
    check("rd_valid_drop", rd_valid, 0);

    // Full sweep 5 + 7
    op_a = 4'd5; op_b = 4'd7;
    sweep(0, 0, bn, da, dn);
    $display("sweep 5/7: busy=%0d done_at=%0d pulses=%0d", bn, da, dn);
    check("s2_busy_cycles", bn, 32);
    check("s2_done_cycle", da, 33);
    check("s2_done_pulses", dn, 1);
    check("s2_sel_hold", alu_sel, 15);
    for (int i = 0; i < 16; i++) begin
      do_read(0, i, d, v);
      $display("read addr %0d -> %0d", i, d);
      check($sformatf("s2_entry%0d", i), d, 32'(12 + i));
    end
    tick();
    check("rd_data_hold", rd_data, 27);
    check("rd_valid_idle", rd_valid, 0);

    // Start asserted mid-sweep must be ignored
    op_a = 4'd5; op_b = 4'd7;
    sweep(0, 10, bn, da, dn);
    $display("sweep with stray start: busy=%0d done_at=%0d pulses=%0d", bn, da, dn);
    check("s3_busy_cycles", bn, 32);
    check("s3_done_cycle", da, 33);
    check("s3_done_pulses", dn, 1);
    check("s3_alu_a_hold", alu_a, 5);
    check("s3_alu_b_hold", alu_b, 7);
    for (int i = 0; i < 16; i += 5) begin
      do_read(0, i, d, v);
      check($sformatf("s3_entry%0d", i), d, 32'(12 + i));
    end

    // Abort by reset at opcode 6
    op_a = 4'd5; op_b = 4'd7;
    start = 1'b1; tick(); start = 1'b0;
    wait_sel(6);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("s4_abort_busy", busy, 0);
    check("s4_abort_sel", alu_sel, 0);
    check("s4_abort_alu_a", alu_a, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) cnt++;
      tick();
    end
    $display("abort: done seen %0d cycles", cnt);
    check("s4_no_done", cnt, 0);
    for (int i = 0; i < 16; i++) begin
      do_read(0, i, d, v);
      check($sformatf("s4_cleared%0d", i), d, 0);
    end
    op_a = 4'd15; op_b = 4'd15;
    sweep(0, 0, bn, da, dn);
    $display("sweep 15/15: busy=%0d done_at=%0d pulses=%0d", bn, da, dn);
    check("s4_done_cycle", da, 33);
    do_read(0, 15, d, v);
    check("s4_entry15", d, 45);
    do_read(0, 0, d, v);
    check("s4_entry0", d, 30);

    // Read and capture of entry 3 on the same edge
    op_a = 4'd5; op_b = 4'd7;
    start = 1'b1; tick(); start = 1'b0;
    wait_sel(3);
    tick();
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    check("s5_old_value", rd_data, 33);
    tick();
    check("s5_new_value", rd_data, 15);
    rd_en = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    $display("collision sweep finished after %0d more cycles", cnt);
    check("s5_done_in_time", 32'(cnt < 60), 1);

    // SETTLE=0 build
    op_a = 4'd5; op_b = 4'd7;
    sweep(1, 0, bn, da, dn);
    $display("settle0 sweep 5/7: busy=%0d done_at=%0d pulses=%0d", bn, da, dn);
    check("s6_busy_cycles", bn, 16);
    check("s6_done_cycle", da, 17);
    check("s6_done_pulses", dn, 1);
    for (int i = 0; i < 16; i++) begin
      do_read(1, i, d, v);
      check($sformatf("s6_entry%0d", i), d, 32'(12 + i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
